// File: rtl/dp_scalar_ctrl.sv
// Left-to-right double-and-add sequencer for R = k*P; point ops run on an external unit
// through a start/done handshake, while point-at-infinity tracking stays local.
module dp_scalar_ctrl #(
  parameter int unsigned KW = 256,
  parameter int unsigned CW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [CW-1:0] Px,
  input  logic [CW-1:0] Py,
  input  logic [KW-1:0] k,
  output logic          out_valid,
  output logic [CW-1:0] Rx,
  output logic [CW-1:0] Ry,
  output logic          out_inf,
  output logic          busy,
  output logic          op_start,
  output logic          op_sel,
  output logic [CW-1:0] op_ax,
  output logic [CW-1:0] op_ay,
  output logic [CW-1:0] op_bx,
  output logic [CW-1:0] op_by,
  input  logic          op_done,
  input  logic [CW-1:0] op_rx,
  input  logic [CW-1:0] op_ry,
  input  logic          op_inf
);

  localparam int unsigned IW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStep,
    StDblStart,
    StDblWait,
    StAddStart,
    StAddWait,
    StDone
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   px_q;
  logic [CW-1:0]   py_q;
  logic [KW-1:0]   k_q;
  logic [CW-1:0]   rx_q;
  logic [CW-1:0]   ry_q;
  logic            r_inf_q;
  logic [IW-1:0]   idx_q;

  logic            out_valid_q;
  logic [CW-1:0]   rx_out_q;
  logic [CW-1:0]   ry_out_q;
  logic            out_inf_q;
  logic            busy_q;
  logic            op_start_q;
  logic            op_sel_q;

  logic            kbit;
  logic            last_bit;

  assign kbit     = k_q[idx_q];
  assign last_bit = (idx_q == '0);

  assign out_valid = out_valid_q;
  assign Rx        = rx_out_q;
  assign Ry        = ry_out_q;
  assign out_inf   = out_inf_q;
  assign busy      = busy_q;
  assign op_start  = op_start_q;
  assign op_sel    = op_sel_q;
  // The accumulator only changes on op_done, so operands stay stable while an op is pending.
  assign op_ax     = rx_q;
  assign op_ay     = ry_q;
  assign op_bx     = px_q;
  assign op_by     = py_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      px_q        <= '0;
      py_q        <= '0;
      k_q         <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      r_inf_q     <= 1'b1;
      idx_q       <= IW'(KW - 1);
      out_valid_q <= 1'b0;
      rx_out_q    <= '0;
      ry_out_q    <= '0;
      out_inf_q   <= 1'b0;
      busy_q      <= 1'b0;
      op_start_q  <= 1'b0;
      op_sel_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      op_start_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy_q still set here means this is the out_valid cycle: drop busy, refuse input.
          busy_q <= 1'b0;
          if (in_valid && !busy_q) begin
            px_q    <= Px;
            py_q    <= Py;
            k_q     <= k;
            r_inf_q <= 1'b1;
            idx_q   <= IW'(KW - 1);
            busy_q  <= 1'b1;
            state_q <= StStep;
          end
        end
        StStep: begin
          if (!r_inf_q) begin
            op_start_q <= 1'b1;
            op_sel_q   <= 1'b0;
            state_q    <= StDblStart;
          end else begin
            if (kbit) begin
              rx_q    <= px_q;
              ry_q    <= py_q;
              r_inf_q <= 1'b0;
            end
            if (last_bit) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q - IW'(1);
              state_q <= StStep;
            end
          end
        end
        StDblStart: begin
          state_q <= StDblWait;
        end
        StDblWait: begin
          if (op_done) begin
            if (kbit && !op_inf) begin
              rx_q       <= op_rx;
              ry_q       <= op_ry;
              r_inf_q    <= 1'b0;
              op_start_q <= 1'b1;
              op_sel_q   <= 1'b1;
              state_q    <= StAddStart;
            end else begin
              // Doubling hit infinity on a 1-bit: restart the accumulator from P.
              if (kbit) begin
                rx_q    <= px_q;
                ry_q    <= py_q;
                r_inf_q <= 1'b0;
              end else begin
                rx_q    <= op_rx;
                ry_q    <= op_ry;
                r_inf_q <= op_inf;
              end
              if (last_bit) begin
                state_q <= StDone;
              end else begin
                idx_q   <= idx_q - IW'(1);
                state_q <= StStep;
              end
            end
          end
        end
        StAddStart: begin
          state_q <= StAddWait;
        end
        StAddWait: begin
          if (op_done) begin
            rx_q    <= op_rx;
            ry_q    <= op_ry;
            r_inf_q <= op_inf;
            if (last_bit) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q - IW'(1);
              state_q <= StStep;
            end
          end
        end
        StDone: begin
          out_valid_q <= 1'b1;
          out_inf_q   <= r_inf_q;
          rx_out_q    <= r_inf_q ? '0 : rx_q;
          ry_out_q    <= r_inf_q ? '0 : ry_q;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_scalar_ctrl.sv
// Directed bench for dp_scalar_ctrl with a D=3 stub point-op unit (x doubles/adds, y passes).
module tb_dp_scalar_ctrl;

  localparam int unsigned KW = 256;
  localparam int unsigned CW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [CW-1:0] Px = '0;
  logic [CW-1:0] Py = '0;
  logic [KW-1:0] k = '0;
  logic          out_valid;
  logic [CW-1:0] Rx;
  logic [CW-1:0] Ry;
  logic          out_inf;
  logic          busy;
  logic          op_start;
  logic          op_sel;
  logic [CW-1:0] op_ax;
  logic [CW-1:0] op_ay;
  logic [CW-1:0] op_bx;
  logic [CW-1:0] op_by;
  logic          op_done = 1'b0;
  logic [CW-1:0] op_rx;
  logic [CW-1:0] op_ry;
  logic          op_inf;

  dp_scalar_ctrl #(
    .KW(KW),
    .CW(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .Px       (Px),
    .Py       (Py),
    .k        (k),
    .out_valid(out_valid),
    .Rx       (Rx),
    .Ry       (Ry),
    .out_inf  (out_inf),
    .busy     (busy),
    .op_start (op_start),
    .op_sel   (op_sel),
    .op_ax    (op_ax),
    .op_ay    (op_ay),
    .op_bx    (op_bx),
    .op_by    (op_by),
    .op_done  (op_done),
    .op_rx    (op_rx),
    .op_ry    (op_ry),
    .op_inf   (op_inf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub point-op: result latched on the op_start cycle, op_done three cycles later.
  logic [CW-1:0] st_x = '0;
  logic [CW-1:0] st_y = '0;
  int            st_cnt = 0;
  always @(posedge clk) begin
    op_done <= 1'b0;
    if (op_start) begin
      st_x   <= op_sel ? (op_ax + op_bx) : (op_ax << 1);
      st_y   <= op_ay;
      st_cnt <= 2;
    end else if (st_cnt == 2) begin
      st_cnt <= 1;
    end else if (st_cnt == 1) begin
      op_done <= 1'b1;
      st_cnt  <= 0;
    end
  end
  assign op_rx  = st_x;
  assign op_ry  = st_y;
  assign op_inf = (st_x == '0);

  int   nops = 0;
  int   nvalid = 0;
  logic sel_q[$];
  always @(negedge clk) begin
    if (op_start === 1'b1) begin
      nops = nops + 1;
      sel_q.push_back(op_sel);
    end
    if (out_valid === 1'b1) nvalid = nvalid + 1;
  end

  int n_tests = 0;
  int n_fail = 0;
  int e0 = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_req(input logic [KW-1:0] kk, input logic [CW-1:0] px,
                           input logic [CW-1:0] py, output logic busy_at_req);
    @(negedge clk);
    busy_at_req = busy;
    k = kk;
    Px = px;
    Py = py;
    in_valid = 1'b1;
    nops = 0;
    nvalid = 0;
    sel_q.delete();
    e0 = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, input int inj_at, output int lat);
    int guard;
    guard = 0;
    lat = -1;
    while (out_valid !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
      in_valid = (inj_at >= 0 && (cyc - e0) == inj_at);
      if (in_valid) begin
        k = 1;
        Px = 100;
        Py = 50;
      end
    end
    in_valid = 1'b0;
    if (out_valid === 1'b1) begin
      lat = cyc - e0;
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid not seen, expected within 5000 cycles", nm);
    end
  endtask

  typedef struct {
    string         name;
    logic [KW-1:0] k;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic [CW-1:0] rx;
    logic [CW-1:0] ry;
    logic          inf;
    int            lat;
    int            nops;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [CW-1:0] msb;
    logic [KW-1:0] ones;
    logic          b;
    logic [7:0]    seq;
    int            lat;

    msb  = {1'b1, 255'd0};
    ones = '1;
    vecs[0] = '{"k1",      1,    7,   9, 7,    9, 1'b0, 257,  0};
    vecs[1] = '{"k5",      5,    7,   9, 35,   9, 1'b0, 269,  3};
    vecs[2] = '{"k0",      0,    7,   9, 0,    0, 1'b1, 257,  0};
    vecs[3] = '{"dbl_inf", 2,    msb, 9, 0,    0, 1'b1, 261,  1};
    vecs[4] = '{"reload",  3,    msb, 5, msb,  5, 1'b0, 261,  1};
    vecs[5] = '{"k3",      3,    4,   6, 12,   6, 1'b0, 265,  2};
    vecs[6] = '{"msb",     msb,  1,   2, msb,  2, 1'b0, 1277, 255};
    vecs[7] = '{"ones",    ones, 1,   3, ones, 3, 1'b0, 2297, 510};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rx", Rx, 0);
    chk("rst_ry", Ry, 0);
    chk("rst_out_inf", out_inf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_start", op_start, 0);
    chk("rst_op_sel", op_sel, 0);

    foreach (vecs[i]) begin
      start_req(vecs[i].k, vecs[i].px, vecs[i].py, b);
      wait_result(vecs[i].name, -1, lat);
      chk({vecs[i].name, "_rx"}, Rx, vecs[i].rx);
      chk({vecs[i].name, "_ry"}, Ry, vecs[i].ry);
      chk({vecs[i].name, "_inf"}, out_inf, vecs[i].inf);
      chk({vecs[i].name, "_busy"}, busy, 1);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_nops"}, nops, vecs[i].nops);
    end

    // Second request mid-run must be ignored; the op order for k=5 is DBL, DBL, ADD.
    start_req(5, 7, 9, b);
    wait_result("ign", 10, lat);
    chk("ign_rx", Rx, 35);
    chk("ign_ry", Ry, 9);
    chk("ign_lat", lat, 269);
    seq = '0;
    foreach (sel_q[i]) seq = {seq[6:0], sel_q[i]};
    chk("ign_nops", nops, 3);
    chk("ign_op_order", seq, 8'b0000_0001);

    // Back-to-back request in the cycle right after out_valid.
    start_req(1, 7, 9, b);
    chk("b2b_busy_at_req", b, 0);
    wait_result("b2b", -1, lat);
    chk("b2b_rx", Rx, 7);
    chk("b2b_lat", lat, 257);
    @(negedge clk);
    chk("b2b_valid_pulse", out_valid, 0);
    chk("b2b_busy_after", busy, 0);

    // Reset during DBL_WAIT; the stub's op_done then lands while the controller is idle.
    start_req(5, 7, 9, b);
    begin
      int guard;
      guard = 0;
      while (op_start !== 1'b1 && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      chk("abort_saw_op_start", op_start, 1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_op_start", op_start, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_valid", nvalid, 0);
    chk("abort_rx", Rx, 0);
    chk("abort_ry", Ry, 0);
    chk("abort_inf", out_inf, 0);
    chk("abort_busy_idle", busy, 0);

    start_req(3, 4, 6, b);
    wait_result("post_abort", -1, lat);
    chk("post_abort_rx", Rx, 12);
    chk("post_abort_ry", Ry, 6);
    chk("post_abort_lat", lat, 265);
    chk("post_abort_nops", nops, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/dp_scalar_ctrl.md
Name: dp_scalar_ctrl

Overview:
- Responder side of the point-multiply handshake: accepts Px, Py and scalar k on a one-cycle in_valid pulse, and returns R = k·P on Rx, Ry with a one-cycle out_valid pulse.
- Left-to-right double-and-add sequencer. Group operations are delegated to an external point-op unit (double/add) through a start/done handshake.
- The controller tracks the point-at-infinity itself and never issues an op that has an infinity operand.

Parameters:
KW, 256, scalar width in bits (bit index runs KW-1..0)
CW, 256, coordinate width in bits

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  one-cycle pulse, Px/Py/k valid
Px  in  CW  base point x
Py  in  CW  base point y
k  in  KW  scalar
out_valid  out  1  one-cycle pulse, Rx/Ry/out_inf valid
Rx  out  CW  result x (0 when out_inf)
Ry  out  CW  result y (0 when out_inf)
out_inf  out  1  result is point at infinity
busy  out  1  high from capture until the out_valid cycle inclusive
op_start  out  1  one-cycle pulse requesting a point op
op_sel  out  1  0 = double(A), 1 = add(A,B)
op_ax, op_ay  out  CW  operand A (accumulator R)
op_bx, op_by  out  CW  operand B (captured P)
op_done  in  1  one-cycle pulse, op result valid
op_rx, op_ry  in  CW  op result
op_inf  in  1  op result is infinity

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0 and the FSM is in IDLE. R_inf=1 and the bit index is KW-1.
- IDLE:
  - in_valid=1 captures Px, Py, k.
  - Sets R_inf=1, idx=KW-1, busy=1, then goes to STEP.
  - in_valid while busy is ignored; the captured operands are unaffected.
- STEP (1 cycle per bit):
  - If R_inf=0, go to DBL_START.
  - Otherwise, if k[idx]=1, load R=P, R_inf=0, and advance the bit.
  - If R_inf=1 and k[idx]=0, just advance the bit.
- DBL_START (1 cycle): op_start=1, op_sel=0, op_a=R.
- DBL_WAIT:
  - Hold the operands stable until op_done.
  - On op_done, R←op_result and R_inf←op_inf.
  - Then go to ADD_START if k[idx]=1 and R_inf=0.
  - If k[idx]=1 and R_inf=1, load R=P and advance.
  - Otherwise advance.
- ADD_START (1 cycle): op_start=1, op_sel=1, A=R, B=P.
- ADD_WAIT: on op_done, R←op_result and R_inf←op_inf, then advance.
- Advance:
  - If idx=0, go to DONE.
  - Otherwise idx←idx-1 and go to STEP.
- DONE (1 cycle):
  - out_valid=1.
  - Rx/Ry=R, or 0 with out_inf=1 when R_inf=1.
  - Next cycle: busy=0, IDLE.
- Rx/Ry/out_inf hold their values after DONE until the next DONE.
- Exactly one op is outstanding at a time.
- op_done in any state other than DBL_WAIT/ADD_WAIT is ignored, including a stale done after reset.
- No timeout: the controller waits for op_done indefinitely.
- Latency, with in_valid sampled at edge E0 and op_done arriving D≥1 cycles after the op_start cycle: out_valid is high in the cycle after edge E0 + KW + 1 + N_ops·(D+1).
- N_ops = (#doubles issued) + (#adds issued). The first 1-bit of k costs no op.
- k=0 gives out_inf=1, Rx=Ry=0, and latency KW+1.
- op_inf=1 mid-run (e.g. P+(−P)) sets R_inf; subsequent doubles are skipped, and the next 1-bit reloads P.
- rst asserted mid-operation aborts immediately: IDLE, op_start=0, busy=0, and no out_valid.

Test Plan:
Bench stub point-op with D=3: double x→2x mod 2^CW with y unchanged; add x→xa+xb with y=ya; op_inf when the result x=0. KW=CW=256.
- k=1, Px=7, Py=9 → no op_start ever; out_valid at E0+257; Rx=7, Ry=9, out_inf=0.
- k=5, Px=7, Py=9 → ops DBL, DBL, ADD in that order; out_valid at E0+269; Rx=35, Ry=9.
- k=0 → out_valid at E0+257, out_inf=1, Rx=Ry=0, zero op_start pulses.
- Px=2^255, k=2 → first double returns x=0 with op_inf=1; the controller skips further doubles; the result is out_inf=1, with out_valid at E0+261.
- Second in_valid pulse at E0+10 during a k=5 run → ignored, result still 35. A back-to-back new request in the cycle after out_valid is accepted.
- rst pulsed during DBL_WAIT, then a stub op_done 2 cycles later → outputs 0, no out_valid. A following k=3, Px=4 request → Rx=12 at E0+265.
